// File: rtl/mcp3008_emu.sv
// MCP3008-compatible SPI ADC slave fed from a packed set of digital channel values.
// miso/miso_oe respond 3 clk after the pin edge; no backpressure, the SPI master clock paces everything.
module mcp3008_emu #(
    parameter int CLK_RATIO_MIN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][9:0] data,
    input  logic            sclk,
    input  logic            csn,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe
);

    // Below this ratio the synchronizer plus edge detect cannot see every sclk phase.
    if (CLK_RATIO_MIN < 4) begin : g_ratio_check
        $fatal(1, "CLK_RATIO_MIN must be at least 4");
    end

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_START = 3'd1;
    localparam logic [2:0] CONFIG     = 3'd2;
    localparam logic [2:0] SAMPLE     = 3'd3;
    localparam logic [2:0] NULLB      = 3'd4;
    localparam logic [2:0] MSB        = 3'd5;
    localparam logic [2:0] LSB        = 3'd6;
    localparam logic [2:0] ZERO       = 3'd7;

    logic [1:0] sclk_sync;
    logic [1:0] csn_sync;
    logic [1:0] mosi_sync;
    logic       sclk_d;
    logic [1:0] sync_fill;
    logic       armed;

    logic [2:0] state;
    logic [3:0] cnt;
    logic [2:0] cfg;
    logic [9:0] hold;

    logic       sclk_s;
    logic       csn_s;
    logic       mosi_s;
    logic       rise;
    logic       fall;
    logic [3:0] cmd;
    logic [3:0] cnt_inc;
    logic [3:0] msb_idx;
    logic [3:0] lsb_idx;
    logic [9:0] chan_a;
    logic [9:0] chan_b;
    logic [9:0] result;

    assign sclk_s = sclk_sync[1];
    assign csn_s  = csn_sync[1];
    assign mosi_s = mosi_sync[1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;

    // {SGL, D2, D1, D0} as seen on the 4th config rise
    assign cmd     = {cfg, mosi_s};
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign msb_idx = 4'd9 - cnt;
    assign lsb_idx = cnt + 4'd1;

    always_comb begin
        chan_a = data[{cmd[2:1], 1'b0}];
        chan_b = data[{cmd[2:1], 1'b1}];
        if (cmd[0]) begin
            chan_a = data[{cmd[2:1], 1'b1}];
            chan_b = data[{cmd[2:1], 1'b0}];
        end
        if (cmd[3]) begin
            result = data[cmd[2:0]];
        end else if (chan_a >= chan_b) begin
            result = chan_a - chan_b;
        end else begin
            result = 10'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            csn_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            cnt       <= 4'd0;
            cfg       <= 3'd0;
            hold      <= 10'd0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            csn_sync  <= {csn_sync[0], csn};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_s;
            sync_fill <= {sync_fill[0], 1'b1};
            // Only a csn level that really came from the pin arms a frame, so a
            // csn held low through reset must go high before the next transfer.
            if (sync_fill[1] && csn_s) begin
                armed <= 1'b1;
            end

            if (csn_s) begin
                state   <= IDLE;
                cnt     <= 4'd0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (rise && mosi_s) begin
                            state <= CONFIG;
                            cnt   <= 4'd0;
                        end
                    end
                    CONFIG: begin
                        if (rise) begin
                            cfg <= cmd[2:0];
                            if (cnt == 4'd3) begin
                                hold  <= result;
                                state <= SAMPLE;
                                cnt   <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (fall) begin
                            miso <= 1'b0;
                            if (miso_oe) begin
                                state <= NULLB;
                            end else begin
                                miso_oe <= 1'b1;
                            end
                        end
                    end
                    NULLB: begin
                        if (fall) begin
                            miso  <= hold[9];
                            state <= MSB;
                            cnt   <= 4'd1;
                        end
                    end
                    MSB: begin
                        if (fall) begin
                            miso <= hold[msb_idx];
                            if (cnt == 4'd9) begin
                                state <= LSB;
                                cnt   <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    LSB: begin
                        if (fall) begin
                            miso <= hold[lsb_idx];
                            if (cnt == 4'd8) begin
                                state <= ZERO;
                                cnt   <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        if (fall) begin
                            miso <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_emu.sv
// Directed bench for mcp3008_emu: drives SPI mode 0 frames and checks returned conversion words.
module tb_mcp3008_emu;

    localparam int HALF = 8;

    logic            clk;
    logic            rst;
    logic [7:0][9:0] data;
    logic            sclk;
    logic            csn;
    logic            mosi;
    logic            miso;
    logic            miso_oe;

    int   n_cmp;
    int   n_err;
    logic last_oe;

    logic [47:0] rx;
    logic [47:0] rxa;
    logic [47:0] rxb;
    logic [47:0] exp_word;

    mcp3008_emu #(.CLK_RATIO_MIN(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .sclk    (sclk),
        .csn     (csn),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Shifts n bits of tx out MSB-first; miso is captured just before each rising sclk.
    task automatic spi_bits(input logic [47:0] tx, input int n, output logic [47:0] rxo);
        rxo = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rxo[i]  = miso;
            last_oe = miso_oe;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic cs_low();
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_cmd(input logic [7:0] cmd_byte, output logic [47:0] rxo);
        cs_low();
        spi_bits({24'd0, 8'h01, cmd_byte, 8'h00}, 24, rxo);
        cs_high();
    endtask

    initial begin
        logic [2:0] ch;
        n_cmp   = 0;
        n_err   = 0;
        last_oe = 1'b0;
        rst  = 1'b1;
        sclk = 1'b0;
        csn  = 1'b1;
        mosi = 1'b0;
        data = {10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};

        repeat (3) @(negedge clk);
        check("reset_miso", {47'd0, miso}, 48'd0);
        check("reset_oe", {47'd0, miso_oe}, 48'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_oe", {47'd0, miso_oe}, 48'd0);

        // single-ended sweep over all channels
        for (int k = 0; k < 8; k++) begin
            ch = k[2:0];
            frame_cmd({1'b1, ch, 4'b0000}, rx);
            check($sformatf("single_ch%0d", k), {38'd0, rx[9:0]}, 48'(k + 1));
            check($sformatf("single_oe_ch%0d", k), {47'd0, last_oe}, 48'd1);
            check($sformatf("single_null_ch%0d", k), {46'd0, rx[11:10]}, 48'd0);
        end
        check("oe_after_frame", {47'd0, miso_oe}, 48'd0);

        // differential: 1-2 saturates, 2-1 = 1
        frame_cmd(8'h00, rx);
        check("diff_000", {38'd0, rx[9:0]}, 48'd0);
        frame_cmd(8'h10, rx);
        check("diff_001", {38'd0, rx[9:0]}, 48'd1);
        data[2] = 10'd500;
        data[3] = 10'd123;
        frame_cmd(8'h20, rx);
        check("diff_010", {38'd0, rx[9:0]}, 48'd377);
        frame_cmd(8'h30, rx);
        check("diff_011_sat", {38'd0, rx[9:0]}, 48'd0);
        data[2] = 10'd3;
        data[7] = 10'h3FF;
        frame_cmd(8'hF0, rx);
        check("single_fullscale", {38'd0, rx[9:0]}, 48'h3FF);
        frame_cmd(8'h70, rx);
        check("diff_111", {38'd0, rx[9:0]}, 48'd1016);
        data[7] = 10'd8;

        // 34-clock frame: MSB-first word, LSB-first repeat, then zeros
        data[3] = 10'h2AA;
        cs_low();
        spi_bits({14'd0, 8'h01, 8'hB0, 8'h00, 10'd0}, 34, rx);
        exp_word = {14'd0, 14'd0, 10'b1010101010, 9'b101010101, 1'b0};
        check("long_frame", rx, exp_word);
        check("long_frame_oe", {47'd0, last_oe}, 48'd1);
        cs_high();
        data[3] = 10'd4;

        // five leading zeros before the start bit
        cs_low();
        spi_bits({26'd0, 5'b00000, 1'b1, 1'b1, 3'd2, 12'd0}, 22, rx);
        cs_high();
        check("lead_zeros", {38'd0, rx[9:0]}, 48'd3);

        // abort after 12 clocks, then csn release latency
        cs_low();
        spi_bits({36'd0, 8'h01, 4'b1000}, 12, rx);
        repeat (4) @(negedge clk);
        check("abort_oe_before", {47'd0, miso_oe}, 48'd1);
        csn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_oe_2clk", {47'd0, miso_oe}, 48'd1);
        @(posedge clk);
        @(negedge clk);
        check("abort_oe_3clk", {47'd0, miso_oe}, 48'd0);
        repeat (HALF) @(negedge clk);
        frame_cmd(8'hD0, rx);
        check("after_abort_ch5", {38'd0, rx[9:0]}, 48'd6);

        // data change mid-frame must not disturb the latched result
        data[0] = 10'd151;
        cs_low();
        spi_bits({32'd0, 8'h01, 8'h80}, 16, rxa);
        data[0] = 10'd99;
        spi_bits(48'd0, 8, rxb);
        cs_high();
        check("hold_stable", {38'd0, rxa[1:0], rxb[7:0]}, 48'd151);
        frame_cmd(8'h80, rx);
        check("hold_next", {38'd0, rx[9:0]}, 48'd99);

        // reset mid-frame with csn held low: no response until csn cycles
        cs_low();
        spi_bits({34'd0, 8'h01, 6'b111100}, 14, rx);
        repeat (4) @(negedge clk);
        check("pre_reset_oe", {47'd0, miso_oe}, 48'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_abort_oe", {47'd0, miso_oe}, 48'd0);
        spi_bits({24'd0, 8'h01, 8'hF0, 8'h00}, 24, rx);
        check("reset_no_frame_rx", rx, 48'd0);
        check("reset_no_frame_oe", {47'd0, last_oe}, 48'd0);
        cs_high();
        frame_cmd(8'hF0, rx);
        check("after_reset_ch7", {38'd0, rx[9:0]}, 48'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcp3008_emu.md
MCP3008_EMU -- requirements
Module: mcp3008_emu

Interface
REQ-001 Parameter CLK_RATIO_MIN, default 8; minimum clk/sclk frequency ratio the block guarantees correct operation for, and not used in logic.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 data  in  8x10  packed analog values; data[k] is channel CHk, 10-bit unsigned.
REQ-005 sclk  in  1  SPI clock, asynchronous to clk, mode 0,0.
REQ-006 csn  in  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  in  1  SPI data in; sampled on sclk rising edge.
REQ-008 miso  out  1  SPI data out; changes on sclk falling edge.
REQ-009 miso_oe  out  1  miso drive enable; 0 means tristate at the top level.

Function
REQ-010 sclk, csn and mosi SHALL each pass through a 2-flop synchronizer on clk.
- An edge detect on the synchronized sclk SHALL produce one-cycle rise/fall strobes.
- Response latency SHALL be 3 clk cycles after the pin edge.
REQ-011 The state machine SHALL have these states: IDLE, WAIT_START, CONFIG, SAMPLE, NULLB, MSB, LSB, ZERO.
REQ-012 While synchronized csn=1, the state SHALL be IDLE, miso_oe=0 and miso=0; this holds in any state, and csn rising mid-transfer aborts the transfer.
REQ-013 On synchronized csn falling, the FSM SHALL go IDLE -> WAIT_START.
REQ-014 In WAIT_START, rise strobes with mosi=0 SHALL be ignored (leading zeros); a rise with mosi=1 SHALL go to CONFIG and clear the bit counter.
REQ-015 CONFIG SHALL shift in 4 bits MSB-first on rise strobes: SGL/DIFF, D2, D1, D0.
- On the 4th rise, the selected result SHALL be latched into a 10-bit holding register, and the FSM goes to SAMPLE.
REQ-016 Single-ended (SGL=1) result SHALL be data[{D2,D1,D0}].
REQ-017 Differential (SGL=0) result SHALL use pair p={D2,D1}.
- D0=0: data[2p] - data[2p+1].
- D0=1: data[2p+1] - data[2p].
- Negative results SHALL saturate to 0.
REQ-018 SAMPLE: miso_oe SHALL assert at the 1st fall strobe after D0, with miso=0; the FSM stays in SAMPLE.
- The 2nd fall strobe SHALL go to NULLB with miso=0 (null bit).
REQ-019 MSB: the next 10 fall strobes SHALL drive result bits B9..B0, in that order.
REQ-020 LSB: the next 9 fall strobes SHALL drive B1..B9 (LSB-first repeat, B0 not repeated).
REQ-021 ZERO: further fall strobes SHALL drive miso=0 with miso_oe=1 until csn rises.
REQ-022 The latched result SHALL NOT change during the frame, even if data changes.
- data changes SHALL take effect only at the next frame's D0 latch.
REQ-023 A rise and fall strobe in the same cycle is impossible under REQ-001.
- If it occurs anyway, the rise SHALL be processed first.
REQ-024 Bit counters SHALL be 4 bits and SHALL saturate, never wrap.

Reset
REQ-025 In the reset cycle the block SHALL set:
- state=IDLE, miso=0, miso_oe=0;
- holding register=0, counters=0;
- synchronizer flops=1 for csn, 0 for sclk and mosi.
REQ-026 Reset asserted mid-frame SHALL abort the frame.
- After reset deasserts, a new frame SHALL require csn high then low.

Verification
REQ-027 data={8,7,6,5,4,3,2,1} (CH0=1 … CH7=8); for each k, send bytes 0x01, {1,k[2:0],4'b0}, 0x00 -> miso bits after the null bit read 10'd(k+1).
REQ-028 Same data, differential D=000 (CH0-CH1 = 1-2) -> result 0 (saturated); D=001 -> result 1.
REQ-029 CH3=10'h2AA, 24+10 clocks in one frame -> sequence null, 1010101010 (MSB), 101010101 (LSB repeat), zeros.
REQ-030 Five leading zero bits before the start bit -> same result as REQ-027 (start bit found correctly).
REQ-031 csn raised after 12 clocks, then a new frame for CH5 -> miso_oe=0 within 3 clk of the csn rise; second frame returns 6.
REQ-032 data[0] changed from 151 to 99 during the MSB phase -> current frame returns 151, next frame returns 99.
